// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
//   Shared definitions for the SRAM-like bus bridge:
//     - state_t  : bridge FSM states (2-bit encoding)
//     - SZ_*     : bus size field encodings (log2 of byte count)
//     - DATA_W_* : legal data widths plus a helper used for elaboration checks
// -----------------------------------------------------------------------------
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam int DATA_W_NARROW = 32;
    localparam int DATA_W_WIDE   = 64;

    function automatic bit data_w_legal(input int w);
        return (w == DATA_W_NARROW) || (w == DATA_W_WIDE);
    endfunction

endpackage

// File: rtl/sram_like_size_enc.sv
// -----------------------------------------------------------------------------
// sram_like_size_enc
//   Combinational decode of a byte write strobe into the bus size field.
//   Ports:
//     i_wen  [DATA_W/8] byte strobe, all-zero means a read
//     o_size [2]        log2 of the byte count
//   Single byte -> SZ_BYTE, aligned byte pair -> SZ_HALF, full word lane or
//   any irregular pattern -> SZ_WORD, full 8-byte strobe -> SZ_DWORD.
//   Reads use the natural bus width.
// -----------------------------------------------------------------------------
module sram_like_size_enc
    import bridge_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0] i_wen,
    output logic [1:0]          o_size
);

    localparam int            NB   = DATA_W / 8;
    localparam logic [NB-1:0] ONE  = NB'(1);
    localparam logic [NB-1:0] PAIR = NB'(3);

    always_comb begin
        // Aligned 4-byte lanes and irregular strobes both land here.
        o_size = SZ_WORD;
        if (i_wen == '0) begin
            o_size = (DATA_W == DATA_W_WIDE) ? SZ_DWORD : SZ_WORD;
        end else if ((NB == 8) && (i_wen == '1)) begin
            o_size = SZ_DWORD;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (i_wen == (ONE << i)) o_size = SZ_BYTE;
            end
            for (int i = 0; i < NB; i += 2) begin
                if (i_wen == (PAIR << i)) o_size = SZ_HALF;
            end
        end
    end

endmodule

// File: rtl/sram_like_bridge.sv
// -----------------------------------------------------------------------------
// sram_like_bridge
//   Turns a stalling CPU load/store port into an SRAM-like request/response
//   bus transaction (req/addr_ok for the address phase, data_ok for data).
//
//   Optional feature macro: BRIDGE_TIMEOUT_EN
//     When defined, a wait counter runs in ADDR/DATA; reaching TIMEOUT_CYC
//     forces completion with cpu_rdata=0 and sets the sticky bus_err flag.
//     When undefined there is no counter and bus_err is tied low.
//
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     cpu_en/wen/addr/wdata  CPU access request (wen=0 means read)
//     cpu_flush              drop the in-flight access (result discarded)
//     cpu_rdata, cpu_stall   load data and pipeline hold
//     req, wr, size, addr,   bus request phase
//     wdata
//     addr_ok, data_ok,      bus handshakes and load data
//     rdata
//     bus_err                sticky timeout flag
// -----------------------------------------------------------------------------
module sram_like_bridge
    import bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic                cpu_flush,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,
    output logic                bus_err
);

    localparam int WB = DATA_W / 8;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("sram_like_bridge: DATA_W must be 32 or 64");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("sram_like_bridge: TIMEOUT_CYC must be at least 1");
    end

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [WB-1:0]       r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_discard;

    logic                w_busy;
    logic                w_accept;
    logic                w_bus_done;
    logic                w_discard;
    logic                w_timeout;

    assign w_busy     = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_accept   = (r_state == ST_IDLE) && cpu_en;
    assign w_bus_done = ((r_state == ST_ADDR) && addr_ok && data_ok) ||
                        ((r_state == ST_DATA) && data_ok);
    // A flush arriving in the completing cycle already counts as a discard.
    assign w_discard  = r_discard || (cpu_flush && w_busy);

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    // r_cnt holds the number of wait cycles already spent, so the cycle in
    // which it equals TIMEOUT_CYC-1 is the TIMEOUT_CYC-th and last one.
    assign w_timeout = w_busy && !w_bus_done && (r_cnt >= CNT_W'(TIMEOUT_CYC - 1));
    assign bus_err   = r_bus_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_accept)    r_cnt <= '0;
            else if (w_busy) r_cnt <= r_cnt + 1'b1;
            if (w_timeout)   r_bus_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (cpu_en) w_next = ST_ADDR;
            ST_ADDR: begin
                if ((addr_ok && data_ok) || w_timeout)
                    w_next = w_discard ? ST_IDLE : ST_DONE;
                else if (addr_ok)
                    w_next = ST_DATA;
            end
            ST_DATA: begin
                if (data_ok || w_timeout)
                    w_next = w_discard ? ST_IDLE : ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req       = (r_state == ST_ADDR);
        wr        = req && (|r_wen);
        // Held low during reset even if cpu_en is still asserted; a discarded
        // access no longer holds the pipeline while it drains on the bus.
        cpu_stall = resetn && (r_state != ST_DONE) &&
                    (cpu_en || (w_busy && !r_discard));
    end

    // Request capture, load data and discard tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= '0;
            r_wen     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_discard <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_wen   <= cpu_wen;
                r_wdata <= cpu_wdata;
            end
            if (w_bus_done && !w_discard)     r_rdata <= rdata;
            else if (w_timeout && !w_discard) r_rdata <= '0;
            if (w_next == ST_IDLE)            r_discard <= 1'b0;
            else if (cpu_flush && w_busy)     r_discard <= 1'b1;
        end
    end

    sram_like_size_enc #(
        .DATA_W (DATA_W)
    ) u_size_enc (
        .i_wen  (r_wen),
        .o_size (size)
    );

    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_like_bridge
//   Self-checking bench: size-decode table, directed corner sequences and
//   randomized transactions checked against a transaction-level model
//   (expected latency = 2 + address wait + data wait; size from strobe rules).
//   Define BRIDGE_TIMEOUT_EN to also exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_sram_like_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cpu_en = 1'b0;
    logic [3:0]    cpu_wen = '0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_flush = 1'b0;
    logic          addr_ok = 1'b0;
    logic          data_ok = 1'b0;
    logic [DW-1:0] rdata = '0;

    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          bus_err;

    int checks = 0;
    int failures = 0;

    sram_like_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Size field from the byte-count rules.
    function automatic logic [1:0] ref_size(input logic [3:0] w);
        int n = 0;
        int lo = -1;
        for (int i = 0; i < 4; i++) begin
            if (w[i]) begin
                n++;
                if (lo < 0) lo = i;
            end
        end
        if (n == 0) return (DW == 64) ? 2'd3 : 2'd2;
        if (n == 1) return 2'd0;
        if (n == 2 && (lo % 2) == 0 && w[lo+1]) return 2'd1;
        if (n == 8) return 2'd3;
        return 2'd2;
    endfunction

    // One complete access: adly extra cycles before addr_ok, then data_ok
    // ddly cycles later (0 = same cycle as addr_ok).
    task automatic txn(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                       input int adly, input int ddly, input logic [31:0] rd,
                       input logic [1:0] esz, input logic ewr);
        step();
        cpu_en = 1; cpu_addr = a; cpu_wen = w; cpu_wdata = wd;
        cpu_flush = 0; addr_ok = 0; data_ok = 0;
        #1;
        chk("idle_stall", cpu_stall, 1);
        for (int k = 0; k <= adly; k++) begin
            step();
            // Scramble CPU inputs to prove the request was captured.
            cpu_addr = ~a; cpu_wdata = ~wd; cpu_wen = ~w;
            addr_ok = (k == adly);
            data_ok = (k == adly) && (ddly == 0);
            rdata = data_ok ? rd : $urandom;
            #1;
            chk("addr_req", req, 1);
            chk("addr_wr", wr, ewr);
            chk("addr_size", size, esz);
            chk("addr_addr", addr, a);
            chk("addr_wdata", wdata, wd);
            chk("addr_stall", cpu_stall, 1);
        end
        for (int k = 1; k <= ddly; k++) begin
            step();
            addr_ok = 0;
            data_ok = (k == ddly);
            rdata = data_ok ? rd : $urandom;
            #1;
            chk("data_req", req, 0);
            chk("data_stall", cpu_stall, 1);
        end
        step();
        addr_ok = 0; data_ok = 0; cpu_en = 0;
        #1;
        chk("done_stall", cpu_stall, 0);
        chk("done_rdata", cpu_rdata, rd);
        chk("done_req", req, 0);
        step();
        #1;
        chk("idle_req", req, 0);
    endtask

    typedef struct {
        logic [3:0] wen;
        logic [1:0] size;
        logic       wr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'b0000, 2'd2, 1'b0};
        tbl[1]  = '{4'b0001, 2'd0, 1'b1};
        tbl[2]  = '{4'b0010, 2'd0, 1'b1};
        tbl[3]  = '{4'b0100, 2'd0, 1'b1};
        tbl[4]  = '{4'b1000, 2'd0, 1'b1};
        tbl[5]  = '{4'b0011, 2'd1, 1'b1};
        tbl[6]  = '{4'b1100, 2'd1, 1'b1};
        tbl[7]  = '{4'b0110, 2'd2, 1'b1};
        tbl[8]  = '{4'b1111, 2'd2, 1'b1};
        tbl[9]  = '{4'b0111, 2'd2, 1'b1};
        tbl[10] = '{4'b1010, 2'd2, 1'b1};
        tbl[11] = '{4'b1001, 2'd2, 1'b1};

        // Reset state, with cpu_en high to show stall is forced low.
        resetn = 0; cpu_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_buserr", bus_err, 0);
        cpu_en = 0;
        resetn = 1;

        // Boot read, single-cycle bus response: 2 stall cycles.
        txn(32'h1FC0_0000, 4'h0, 32'h0, 0, 0, 32'h3C1D_0001, 2'd2, 1'b0);
        // Halfword store, data_ok two cycles after addr_ok.
        txn(32'h8000_0010, 4'h3, 32'h0000_BEEF, 0, 2, 32'h0, 2'd1, 1'b1);
        // addr_ok delayed 4 cycles: request held 5 cycles.
        txn(32'hA000_0040, 4'hF, 32'h1234_5678, 4, 0, 32'h9ABC_DEF0, 2'd2, 1'b1);

        foreach (tbl[i])
            txn($urandom, tbl[i].wen, $urandom, 0, 0, $urandom, tbl[i].size, tbl[i].wr);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] w;
            w = 4'($urandom_range(0, 15));
            txn($urandom, w, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, ref_size(w), |w);
        end

        // Flush in DATA: result discarded, rdata kept, next access immediate.
        txn(32'h0000_1000, 4'h0, 32'h0, 0, 0, 32'h1122_3344, 2'd2, 1'b0);
        step(); cpu_en = 1; cpu_addr = 32'h2000; cpu_wen = 0; #1;
        step(); addr_ok = 1; #1;
        chk("fl_req", req, 1);
        step(); addr_ok = 0; cpu_flush = 1; #1;
        chk("fl_stall_hold", cpu_stall, 1);
        chk("fl_data_req", req, 0);
        step(); cpu_flush = 0; cpu_en = 0; data_ok = 1; rdata = 32'hDEAD_BEEF; #1;
        chk("fl_stall_rel", cpu_stall, 0);
        step(); data_ok = 0; cpu_en = 1; cpu_addr = 32'h3000; #1;
        chk("fl_rdata_kept", cpu_rdata, 32'h1122_3344);
        chk("fl_new_stall", cpu_stall, 1);
        step(); addr_ok = 1; data_ok = 1; rdata = 32'hCAFE_0001; #1;
        chk("fl_next_req", req, 1);
        chk("fl_next_addr", addr, 32'h3000);
        step(); addr_ok = 0; data_ok = 0; cpu_en = 0; #1;
        chk("fl_next_rdata", cpu_rdata, 32'hCAFE_0001);

        // Flush together with addr_ok and data_ok: discard wins, back to IDLE.
        step(); cpu_en = 1; cpu_addr = 32'h4000; cpu_wen = 0; #1;
        step(); cpu_flush = 1; addr_ok = 1; data_ok = 1; rdata = 32'h55AA_55AA; #1;
        chk("cf_req", req, 1);
        step(); cpu_flush = 0; addr_ok = 0; data_ok = 0; #1;
        chk("cf_idle_req", req, 0);
        chk("cf_accept_stall", cpu_stall, 1);
        chk("cf_rdata_kept", cpu_rdata, 32'hCAFE_0001);
        step(); addr_ok = 1; data_ok = 1; rdata = 32'h0BAD_F00D; #1;
        chk("cf_next_req", req, 1);
        step(); addr_ok = 0; data_ok = 0; cpu_en = 0; #1;
        chk("cf_next_rdata", cpu_rdata, 32'h0BAD_F00D);

        // Reset in the middle of DATA, then a stray data_ok.
        step(); cpu_en = 1; cpu_addr = 32'h5000; cpu_wen = 0; #1;
        step(); addr_ok = 1; #1;
        step(); addr_ok = 0; #1;
        chk("rd_stall_pre", cpu_stall, 1);
        #2; resetn = 0; #1;
        chk("rd_req", req, 0);
        chk("rd_stall", cpu_stall, 0);
        chk("rd_rdata", cpu_rdata, 0);
        step(); resetn = 1; cpu_en = 0; data_ok = 1; rdata = 32'h7777_7777; #1;
        chk("rd_stray_req", req, 0);
        step(); data_ok = 0; cpu_en = 1; cpu_addr = 32'h5100; #1;
        chk("rd_stray_rdata", cpu_rdata, 0);
        chk("rd_stray_stall", cpu_stall, 1);
        step(); addr_ok = 1; data_ok = 1; rdata = 32'h2468_ACE0; #1;
        chk("rd_next_req", req, 1);
        step(); addr_ok = 0; data_ok = 0; cpu_en = 0; #1;
        chk("rd_next_rdata", cpu_rdata, 32'h2468_ACE0);

`ifdef BRIDGE_TIMEOUT_EN
        // No addr_ok: forced completion after TO cycles of waiting.
        begin
            int  waits;
            bit  seen;
            waits = 0;
            seen = 0;
            step(); cpu_en = 1; cpu_addr = 32'h6000; cpu_wen = 0; #1;
            for (int k = 0; k < 20 && !seen; k++) begin
                step(); #1;
                if (!cpu_stall) seen = 1;
                else waits++;
            end
            cpu_en = 0;
            chk("to_seen", seen, 1);
            chk("to_cycles", waits, TO);
            chk("to_rdata", cpu_rdata, 0);
            chk("to_buserr", bus_err, 1);
            step(); #1;
            chk("to_sticky", bus_err, 1);
            txn(32'h6100, 4'h0, 32'h0, 1, 1, 32'h1357_9BDF, 2'd2, 1'b0);
            chk("to_sticky2", bus_err, 1);
            resetn = 0; #1;
            chk("to_rst_clear", bus_err, 0);
            step(); resetn = 1;
        end
`else
        // Without the timeout feature the bridge simply keeps waiting.
        step(); cpu_en = 1; cpu_addr = 32'h6000; cpu_wen = 0; #1;
        repeat (20) step();
        chk("nto_req_held", req, 1);
        chk("nto_stall_held", cpu_stall, 1);
        chk("nto_buserr", bus_err, 0);
        cpu_en = 0; resetn = 0; #1;
        chk("nto_rst_req", req, 0);
        step(); resetn = 1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
